// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the TX response scheduler: FSM states,
// response sources and per-source byte counts.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        SRC_RF  = 1'b0,
        SRC_ALU = 1'b1
    } src_e;

    localparam logic [1:0] RF_BYTES  = 2'd1;
    localparam logic [1:0] ALU_BYTES = 2'd2;

    // A lone full slot always wins; the round-robin pointer only settles a tie.
    function automatic src_e pick_src(input logic rf_full,
                                      input logic alu_full,
                                      input src_e rr);
        src_e win;
        if (rf_full && alu_full) begin
            win = rr;
        end else if (alu_full) begin
            win = SRC_ALU;
        end else begin
            win = SRC_RF;
        end
        return win;
    endfunction

    function automatic src_e other_src(input src_e s);
        return (s == SRC_RF) ? SRC_ALU : SRC_RF;
    endfunction

endpackage

// File: rtl/tx_slot.sv
// One-entry holding register for a single response source. A capture in the
// same cycle the slot is freed refills it without flagging an overflow.
module tx_slot
    import tx_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         vld,
    input  logic [W-1:0] data,
    input  logic         free,
    output logic         full,
    output logic [W-1:0] q,
    output logic         ovf
);

    logic         full_reg;
    logic [W-1:0] q_reg;
    logic         ovf_reg;
    logic         accept;

    assign accept = vld && (!full_reg || free);

    always_ff @(posedge clk) begin
        if (srst) begin
            full_reg <= 1'b0;
            q_reg    <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            ovf_reg <= vld && full_reg && !free;
            if (accept) begin
                full_reg <= 1'b1;
                q_reg    <= data;
            end else if (free) begin
                full_reg <= 1'b0;
            end
        end
    end

    assign full = full_reg;
    assign q    = q_reg;
    assign ovf  = ovf_reg;

endmodule

// File: rtl/tx_resp_sched.sv
// Round-robin scheduler of RF / ALU responses onto the UART TX byte port with a
// level handshake against the synchronized busy flag. Optional feature macro:
// TX_ACK_TIMEOUT_EN (abort a byte whose busy acknowledge never arrives).
module tx_resp_sched
    import tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    UART_TX_Busy,
    output logic [DATA_WIDTH-1:0]   UART_TX_DATA,
    output logic                    UART_TX_VLD,
    output logic                    SCHED_BUSY,
    output logic                    OVF_ERR,
    output logic                    TIMEOUT_ERR
);

    localparam int FW = 2 * DATA_WIDTH;

    logic                  rf_full, alu_full;
    logic                  rf_ovf, alu_ovf;
    logic                  rf_free, alu_free;
    logic [DATA_WIDTH-1:0] rf_q;
    logic [FW-1:0]         alu_q;

    state_e                state_reg;
    src_e                  rr_reg;
    logic [FW-1:0]         shift_reg;
    logic [1:0]            bytes_left_reg;
    logic                  tx_vld_reg;
    logic                  ovf_reg;

    logic                  grant;
    src_e                  grant_src;

    tx_slot #(.W(DATA_WIDTH)) u_rf_slot (
        .clk  (CLK),
        .srst (RST),
        .vld  (RF_RdData_VLD),
        .data (RF_RdData),
        .free (rf_free),
        .full (rf_full),
        .q    (rf_q),
        .ovf  (rf_ovf)
    );

    tx_slot #(.W(FW)) u_alu_slot (
        .clk  (CLK),
        .srst (RST),
        .vld  (ALU_OUT_VLD),
        .data (ALU_OUT),
        .free (alu_free),
        .full (alu_full),
        .q    (alu_q),
        .ovf  (alu_ovf)
    );

    // Busy is checked at grant so a byte is never offered while the TX side is
    // still finishing something it owns.
    assign grant     = (state_reg == ST_IDLE) && (rf_full || alu_full) && !UART_TX_Busy;
    assign grant_src = pick_src(rf_full, alu_full, rr_reg);
    assign rf_free   = grant && (grant_src == SRC_RF);
    assign alu_free  = grant && (grant_src == SRC_ALU);

`ifdef TX_ACK_TIMEOUT_EN
    localparam int            TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             tmo_err_reg;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            rr_reg         <= SRC_RF;
            shift_reg      <= '0;
            bytes_left_reg <= 2'd0;
            tx_vld_reg     <= 1'b0;
`ifdef TX_ACK_TIMEOUT_EN
            tmo_cnt_reg    <= '0;
            tmo_err_reg    <= 1'b0;
`endif
        end else begin
`ifdef TX_ACK_TIMEOUT_EN
            tmo_err_reg <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (grant) begin
                        if (rf_full && alu_full) begin
                            rr_reg <= other_src(rr_reg);
                        end
                        if (grant_src == SRC_ALU) begin
                            shift_reg      <= alu_q;
                            bytes_left_reg <= ALU_BYTES;
                        end else begin
                            shift_reg      <= {{DATA_WIDTH{1'b0}}, rf_q};
                            bytes_left_reg <= RF_BYTES;
                        end
                        tx_vld_reg <= 1'b1;
                        state_reg  <= ST_SEND;
`ifdef TX_ACK_TIMEOUT_EN
                        tmo_cnt_reg <= '0;
`endif
                    end
                end

                ST_SEND: begin
                    if (UART_TX_Busy) begin
                        tx_vld_reg <= 1'b0;
                        state_reg  <= ST_DRAIN;
                    end
`ifdef TX_ACK_TIMEOUT_EN
                    else if (tmo_cnt_reg == TMO_LAST) begin
                        // The remaining bytes of the frame are dropped with it.
                        tx_vld_reg     <= 1'b0;
                        bytes_left_reg <= 2'd0;
                        tmo_err_reg    <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
`endif
                end

                ST_DRAIN: begin
                    if (!UART_TX_Busy) begin
                        if (bytes_left_reg > 2'd1) begin
                            shift_reg      <= {{DATA_WIDTH{1'b0}}, shift_reg[FW-1:DATA_WIDTH]};
                            bytes_left_reg <= bytes_left_reg - 2'd1;
                            tx_vld_reg     <= 1'b1;
                            state_reg      <= ST_SEND;
`ifdef TX_ACK_TIMEOUT_EN
                            tmo_cnt_reg    <= '0;
`endif
                        end else begin
                            bytes_left_reg <= 2'd0;
                            state_reg      <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    tx_vld_reg <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= rf_ovf || alu_ovf;
        end
    end

    assign UART_TX_DATA = shift_reg[DATA_WIDTH-1:0];
    assign UART_TX_VLD  = tx_vld_reg;
    assign SCHED_BUSY   = rf_full || alu_full || (state_reg != ST_IDLE);
    assign OVF_ERR      = ovf_reg;

`ifdef TX_ACK_TIMEOUT_EN
    assign TIMEOUT_ERR = tmo_err_reg;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_tx_resp_sched.sv
// Self-checking bench for tx_resp_sched: directed scenarios plus random frames
// compared against a frame-level model of arbitration and byte order.
module tb_tx_resp_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        UART_TX_Busy;
    logic [7:0]  UART_TX_DATA;
    logic        UART_TX_VLD;
    logic        SCHED_BUSY;
    logic        OVF_ERR;
    logic        TIMEOUT_ERR;

    int checks = 0;
    int errors = 0;

    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    int  ovf_seen = 0;
    int  tmo_seen = 0;
    int  exp_tmo  = 0;
    bit  busy_en   = 1'b1;
    bit  model_rst = 1'b1;
    bit  rr_alu    = 1'b0;

    always #5 CLK = ~CLK;

    tx_resp_sched #(.DATA_WIDTH(8), .TIMEOUT_CYC(16)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RF_RdData     (RF_RdData),
        .RF_RdData_VLD (RF_RdData_VLD),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VLD   (ALU_OUT_VLD),
        .UART_TX_Busy  (UART_TX_Busy),
        .UART_TX_DATA  (UART_TX_DATA),
        .UART_TX_VLD   (UART_TX_VLD),
        .SCHED_BUSY    (SCHED_BUSY),
        .OVF_ERR       (OVF_ERR),
        .TIMEOUT_ERR   (TIMEOUT_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // TX-side model: accepts a byte after a random delay, stays busy a random time.
    initial begin
        int  rise_dly;
        int  hold;
        bit  rose_prev;
        rise_dly = 0;
        hold = 0;
        rose_prev = 1'b0;
        UART_TX_Busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (OVF_ERR === 1'b1) ovf_seen++;
            if (TIMEOUT_ERR === 1'b1) tmo_seen++;
            if (rose_prev && !model_rst) chk("vld_drop_on_busy", UART_TX_VLD, 0);
            rose_prev = 1'b0;
            if (model_rst) begin
                UART_TX_Busy = 1'b0;
                rise_dly = 0;
            end else if (UART_TX_Busy) begin
                if (hold == 0) UART_TX_Busy = 1'b0;
                else hold--;
            end else if (UART_TX_VLD === 1'b1 && busy_en) begin
                if (rise_dly == 0) begin
                    UART_TX_Busy = 1'b1;
                    hold = $urandom_range(0, 3);
                    rise_dly = $urandom_range(0, 3);
                    sent_q.push_back(UART_TX_DATA);
                    rose_prev = 1'b1;
                    $display("tx byte %02h", UART_TX_DATA);
                end else begin
                    rise_dly--;
                end
            end
        end
    end

    task automatic pulse(input bit rf, input logic [7:0] rd, input bit alu, input logic [15:0] ad);
        @(negedge CLK);
        RF_RdData = rd;
        RF_RdData_VLD = rf;
        ALU_OUT = ad;
        ALU_OUT_VLD = alu;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0;
        ALU_OUT_VLD = 1'b0;
    endtask

    // Frame-level expectation: RF sends one byte, ALU sends LSB then MSB; a
    // simultaneous pair goes in round-robin order and toggles the pointer.
    task automatic model_push(input int kind, input logic [7:0] rd, input logic [15:0] ad);
        if (kind == 0) begin
            exp_q.push_back(rd);
        end else if (kind == 1) begin
            exp_q.push_back(ad[7:0]);
            exp_q.push_back(ad[15:8]);
        end else begin
            if (!rr_alu) begin
                exp_q.push_back(rd);
                exp_q.push_back(ad[7:0]);
                exp_q.push_back(ad[15:8]);
            end else begin
                exp_q.push_back(ad[7:0]);
                exp_q.push_back(ad[15:8]);
                exp_q.push_back(rd);
            end
            rr_alu = !rr_alu;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((SCHED_BUSY !== 1'b0 || UART_TX_Busy !== 1'b0) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_idle_timeout"}, (n >= 500) ? 1 : 0, 0);
    endtask

    task automatic compare_frames(input string tag);
        chk({tag, "_count"}, sent_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), sent_q[i], exp_q[i]);
        $display("%s: %0d bytes sent, %0d expected", tag, sent_q.size(), exp_q.size());
        sent_q.delete();
        exp_q.delete();
    endtask

    initial begin
        RST = 1'b1;
        RF_RdData = '0;
        RF_RdData_VLD = 1'b0;
        ALU_OUT = '0;
        ALU_OUT_VLD = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_tx_vld", UART_TX_VLD, 0);
        chk("rst_sched_busy", SCHED_BUSY, 0);
        chk("rst_ovf", OVF_ERR, 0);
        chk("rst_tmo", TIMEOUT_ERR, 0);
        chk("rst_tx_data", UART_TX_DATA, 0);
        RST = 1'b0;
        model_rst = 1'b0;
        @(negedge CLK);

        // RF byte: latency n+2 and a single frame.
        @(negedge CLK);
        RF_RdData = 8'hA5;
        RF_RdData_VLD = 1'b1;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0;
        chk("t1_vld_n1", UART_TX_VLD, 0);
        @(negedge CLK);
        chk("t1_vld_n2", UART_TX_VLD, 1);
        chk("t1_data", UART_TX_DATA, 8'hA5);
        model_push(0, 8'hA5, 16'h0);
        wait_idle("t1");
        compare_frames("t1");

        // ALU result: LSB then MSB.
        pulse(1'b0, 8'h00, 1'b1, 16'h1234);
        model_push(1, 8'h00, 16'h1234);
        wait_idle("t2");
        compare_frames("t2");

        // Simultaneous pair twice: RF first, then ALU first.
        pulse(1'b1, 8'h11, 1'b1, 16'hBEEF);
        model_push(2, 8'h11, 16'hBEEF);
        wait_idle("t3a");
        compare_frames("t3a");
        pulse(1'b1, 8'h11, 1'b1, 16'hBEEF);
        model_push(2, 8'h11, 16'hBEEF);
        wait_idle("t3b");
        compare_frames("t3b");

        // Overflow: ALU frame occupies the FSM while RF slot is hit twice.
        ovf_seen = 0;
        @(negedge CLK);
        ALU_OUT = 16'h5678;
        ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        RF_RdData = 8'h01;
        RF_RdData_VLD = 1'b1;
        @(negedge CLK);
        RF_RdData = 8'h02;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0;
        model_push(1, 8'h00, 16'h5678);
        model_push(0, 8'h01, 16'h0);
        wait_idle("t4");
        chk("t4_ovf_pulses", ovf_seen, 1);
        compare_frames("t4");

        // Random single-command traffic.
        ovf_seen = 0;
        for (int t = 0; t < 40; t++) begin
            int          kind;
            logic [7:0]  rd;
            logic [15:0] ad;
            kind = $urandom_range(0, 2);
            rd = 8'($urandom);
            ad = 16'($urandom);
            pulse(kind != 1, rd, kind != 0, ad);
            model_push(kind, rd, ad);
            wait_idle($sformatf("rnd%0d", t));
            compare_frames($sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        chk("rnd_no_ovf", ovf_seen, 0);

`ifdef TX_ACK_TIMEOUT_EN
        begin
            int n;
            busy_en = 1'b0;
            pulse(1'b1, 8'h77, 1'b0, 16'h0);
            @(negedge CLK);
            chk("t6_vld", UART_TX_VLD, 1);
            n = 1;
            while (UART_TX_VLD === 1'b1 && n < 100) begin
                @(negedge CLK);
                if (UART_TX_VLD === 1'b1) n++;
            end
            chk("t6_send_cycles", n, 16);
            chk("t6_tmo_err", TIMEOUT_ERR, 1);
            chk("t6_sched_busy", SCHED_BUSY, 0);
            exp_tmo = 1;
            @(negedge CLK);
            busy_en = 1'b1;
        end
`endif
        chk("tmo_pulses", tmo_seen, exp_tmo);

        // Reset in the middle of the first ALU byte.
        busy_en = 1'b0;
        pulse(1'b0, 8'h00, 1'b1, 16'h1234);
        @(negedge CLK);
        chk("t5_vld_before", UART_TX_VLD, 1);
        chk("t5_data_before", UART_TX_DATA, 8'h34);
        RST = 1'b1;
        model_rst = 1'b1;
        @(negedge CLK);
        chk("t5_vld_after", UART_TX_VLD, 0);
        chk("t5_busy_after", SCHED_BUSY, 0);
        RST = 1'b0;
        model_rst = 1'b0;
        busy_en = 1'b1;
        rr_alu = 1'b0;
        repeat (20) @(negedge CLK);
        chk("t5_no_bytes", sent_q.size(), 0);
        chk("t5_vld_idle", UART_TX_VLD, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
